alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ERR_RESULT, default 8'h00, result value returned for an unsupported opcode.
REQ-002 Parameter: CNT_W, default 16, width of each per-requester grant counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0_valid / req1_valid  in  1  requester k presents an operation.
REQ-007 req0_ready / req1_ready  out  1  operation of requester k is accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  8  operands.
REQ-009 req0_op / req1_op  in  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLT unsigned, 1001 SHL, 1010 SHR.
REQ-010 rsp_valid  out  1  response register holds a result.
REQ-011 rsp_ready  in  1  consumer accepts the response.
REQ-012 rsp_id  out  1  index of the requester that owns the response.
REQ-013 rsp_result  out  8  ALU result.
REQ-014 rsp_err  out  1  opcode was unsupported.
REQ-015 grant_cnt0 / grant_cnt1  out  CNT_W  accepted-operation counters.

Function
REQ-016 The block uses two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 can_accept = EMPTY or (FULL and rsp_ready); a transfer on requester k occurs when reqk_valid and reqk_ready are both 1.
REQ-018 reqk_ready = can_accept and grant==k; at most one ready is high per cycle.
REQ-019 Grant is round-robin: a lone valid requester is granted; with both valid, the requester not granted at the last transfer is granted.
REQ-020 The priority pointer shall update only on a transfer, never on an idle cycle.
REQ-021 ready may depend combinationally on valid and rsp_ready; valid shall not depend on ready.
REQ-022 On a transfer, at the next edge: rsp_result = ALU(a, b, op) of the granted requester; rsp_id = k; rsp_err = 0; state = FULL.
REQ-023 An unsupported opcode produces rsp_result = ERR_RESULT and rsp_err = 1; the X default of the ALU shall never reach rsp_result.
REQ-024 Arithmetic is 8-bit modulo; ADD/SUB wrap; a shift amount of 8 or more yields 0.
REQ-025 Latency is exactly one cycle from transfer to rsp_valid; throughput is one operation per cycle while rsp_ready=1.
REQ-026 When FULL and rsp_ready=0, rsp_* are held stable and both readys are 0.
REQ-027 When FULL, rsp_ready=1 and no transfer occurs, the state becomes EMPTY at the next edge.
REQ-028 When FULL, rsp_ready=1 and a transfer occurs, the response is replaced in the same edge and the state stays FULL.
REQ-029 grant_cntk increments on each transfer of requester k and saturates at all-ones.

Reset
REQ-030 Asserting rst_n low immediately forces: state EMPTY; rsp_valid=0; rsp_result=0; rsp_id=0; rsp_err=0; grant counters 0; priority pointer favouring requester 0.
REQ-031 Reset mid-operation discards any held response; no partial transfer survives reset.
REQ-032 Release of rst_n is synchronised by the system; the first transfer may occur in the first cycle after release.

Structure
REQ-033 Opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SHL, OP_SHR) and the EMPTY/FULL state encoding reside in shared package alu_pkg.
REQ-034 The block instantiates exactly one existing combinational ALU sub-module, fed by a grant-selected operand mux; unsupported-opcode detection uses alu_pkg constants.

Verification
REQ-035 Single requester: req0 a=8'h0F, b=8'h01, op=ADD, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=8'h10, rsp_id=0, rsp_err=0.
REQ-036 Contention: both valid for 4 cycles, rsp_ready=1 -> grants alternate 0,1,0,1; grant_cnt0=2, grant_cnt1=2.
REQ-037 Backpressure: rsp_ready=0 for 3 cycles after a SUB 8'h00-8'h01 -> rsp_result held at 8'hFF, both readys 0, no counter change.
REQ-038 Illegal opcode 4'b1111 -> rsp_result=8'h00, rsp_err=1; legal SHL a=8'h81, b=1 -> 8'h02; SHR b=9 -> 8'h00.
REQ-039 Reset while FULL -> rsp_valid drops asynchronously before the next edge; counters read 0; the first grant after reset with both valid goes to requester 0.
REQ-040 Saturation with CNT_W=4: 17 transfers from req1 -> grant_cnt1 = 4'hF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcode encodings, the
// response-register state encoding and an opcode legality helper.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;

    // Response register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // True for every opcode the ALU implements.
    function automatic logic op_supported(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SLT, OP_SHL, OP_SHR: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU. Unsupported opcodes produce X; the caller
// is responsible for masking them.
module alu_core
    import alu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_op,
    output logic [7:0] o_y
);

    // Decode the opcode and compute the 8-bit modulo result.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred; X here lets synthesis optimise the
        // don't-care opcodes.
        o_y = 'x;
        case (i_op)
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_ADD: o_y = i_a + i_b;
            OP_SUB: o_y = i_a - i_b;
            OP_SLT: o_y = {7'd0, (i_a < i_b)};
            OP_SHL: o_y = (i_b >= 8'd8) ? 8'h00 : (i_a << i_b[2:0]);
            OP_SHR: o_y = (i_b >= 8'd8) ? 8'h00 : (i_a >> i_b[2:0]);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a single
// registered response slot and per-requester saturating grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter logic [7:0] ERR_RESULT = 8'h00,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic             rsp_err,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_last;          // requester granted at the last transfer
    logic [7:0]       r_rsp_result;
    logic             r_rsp_id;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_can_accept;
    logic             w_grant;
    logic             w_xfer;
    logic [7:0]       w_a;
    logic [7:0]       w_b;
    logic [3:0]       w_op;
    logic [7:0]       w_alu_y;
    logic             w_op_ok;

    // The slot can take a new operation when empty or being drained this cycle.
    assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready;

    // Round-robin: a lone requester wins; under contention the one not
    // served last time wins. With no requester the grant idles at 0.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;

    assign req0_ready = w_can_accept && !w_grant;
    assign req1_ready = w_can_accept &&  w_grant;
    assign w_xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Operand mux feeding the single shared ALU.
    assign w_a  = w_grant ? req1_a  : req0_a;
    assign w_b  = w_grant ? req1_b  : req0_b;
    assign w_op = w_grant ? req1_op : req0_op;

    alu_core u_alu (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_op (w_op),
        .o_y  (w_alu_y)
    );

    assign w_op_ok = op_supported(w_op);

    // State register for the response slot.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_next;
    end

    // Next-state logic: a transfer always fills the slot; a drain without
    // a refill empties it; otherwise the slot holds.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_next = ST_FULL;
            ST_FULL: begin
                if (w_xfer)         w_state_next = ST_FULL;
                else if (rsp_ready) w_state_next = ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Capture the response of the granted operation; an illegal opcode is
    // replaced by ERR_RESULT so the ALU's X never escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= 8'h00;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else if (w_xfer) begin
            r_rsp_result <= w_op_ok ? w_alu_y : ERR_RESULT;
            r_rsp_id     <= w_grant;
            r_rsp_err    <= !w_op_ok;
        end
    end

    // Priority pointer moves only on a transfer; reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_last <= 1'b1;
        else if (w_xfer) r_last <= w_grant;
    end

    // Saturating per-requester transfer counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_xfer) begin
            if (!w_grant && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if ( w_grant && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign rsp_valid  = (r_state == ST_FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by random
// traffic, all checked against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [7:0]    req0_a, req0_b, req1_a, req1_b;
    logic [3:0]    req0_op, req1_op;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [7:0]    rsp_result;
    logic [CW-1:0] grant_cnt0, grant_cnt1;

    alu_arbiter #(.ERR_RESULT(8'h00), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic       err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference-model state.
    bit m_full = 1'b0;
    bit m_last = 1'b1;
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU written from the opcode table with plain arithmetic.
    function automatic rsp_t ref_alu(input bit id, input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] op);
        rsp_t r;
        int   ia = int'(a);
        int   ib = int'(b);
        r.id  = id;
        r.err = 1'b0;
        case (op)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0010: r.res = 8'((ia + ib) % 256);
            4'b0110: r.res = 8'((ia - ib + 256) % 256);
            4'b1000: r.res = (ia < ib) ? 8'd1 : 8'd0;
            4'b1001: r.res = (ib >= 8) ? 8'd0 : 8'((ia * (1 << ib)) % 256);
            4'b1010: r.res = (ib >= 8) ? 8'd0 : 8'(ia / (1 << ib));
            default: begin r.res = 8'h00; r.err = 1'b1; end
        endcase
        return r;
    endfunction

    // Model process: predicts readys, transfers, occupancy and counters.
    initial begin
        bit can, g;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                m_full = 1'b0;
                m_last = 1'b1;
                m_cnt0 = 0;
                m_cnt1 = 0;
                sb.delete();
            end else begin
                check("rsp_valid", rsp_valid, m_full);
                check("grant_cnt0", grant_cnt0, m_cnt0);
                check("grant_cnt1", grant_cnt1, m_cnt1);
                can = !m_full || rsp_ready;
                if (req0_valid || req1_valid) begin
                    g = (req0_valid && req1_valid) ? !m_last : req1_valid;
                    check("req0_ready", req0_ready, can && !g);
                    check("req1_ready", req1_ready, can &&  g);
                    if (can) begin
                        sb.push_back(g ? ref_alu(1'b1, req1_a, req1_b, req1_op)
                                       : ref_alu(1'b0, req0_a, req0_b, req0_op));
                        if (g) m_cnt1 = (m_cnt1 < 15) ? m_cnt1 + 1 : 15;
                        else   m_cnt0 = (m_cnt0 < 15) ? m_cnt0 + 1 : 15;
                        m_last = g;
                        m_full = 1'b1;
                    end
                end else if (m_full && rsp_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented response with the scoreboard head
    // and retires it when the consumer takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id=%0d result=%0h with no expected entry at %0t",
                             rsp_id, rsp_result, $time);
                end else begin
                    check("rsp_id", rsp_id, sb[0].id);
                    check("rsp_result", rsp_result, sb[0].res);
                    check("rsp_err", rsp_err, sb[0].err);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set0(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    endtask

    task automatic set1(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    logic [3:0] op_tab [8];

    initial begin
        op_tab[0] = 4'b0000; op_tab[1] = 4'b0001; op_tab[2] = 4'b0010; op_tab[3] = 4'b0110;
        op_tab[4] = 4'b1000; op_tab[5] = 4'b1001; op_tab[6] = 4'b1010; op_tab[7] = 4'b1111;

        rst_n = 1'b1;
        rsp_ready = 1'b0;
        set0(1'b0, 8'h00, 8'h00, 4'b0000);
        set1(1'b0, 8'h00, 8'h00, 4'b0000);
        #1 rst_n = 1'b0;
        cycle();
        cycle();

        // Reset state.
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_result", rsp_result, 8'h00);
        check("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_cnt0", grant_cnt0, 0);
        check("rst_cnt1", grant_cnt1, 0);
        rst_n = 1'b1;

        // Single requester ADD, one-cycle latency.
        rsp_ready = 1'b1;
        set0(1'b1, 8'h0F, 8'h01, 4'b0010);
        cycle();
        idle();
        check("add_valid", rsp_valid, 1'b1);
        check("add_result", rsp_result, 8'h10);
        check("add_id", rsp_id, 1'b0);
        check("add_err", rsp_err, 1'b0);
        cycle();

        // Contention: four back-to-back grants alternate starting at 0.
        apply_reset();
        rsp_ready = 1'b1;
        set0(1'b1, 8'h11, 8'h22, 4'b0001);
        set1(1'b1, 8'h33, 8'h0F, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_id", rsp_id, i % 2);
        end
        idle();
        check("rr_cnt0", grant_cnt0, 2);
        check("rr_cnt1", grant_cnt1, 2);

        // Backpressure: SUB wraps to FF and is held for 3 cycles.
        set0(1'b1, 8'h00, 8'h01, 4'b0110);
        cycle();
        rsp_ready = 1'b0;
        set1(1'b1, 8'h44, 8'h01, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready0", req0_ready, 1'b0);
            check("bp_ready1", req1_ready, 1'b0);
            cycle();
            check("bp_result", rsp_result, 8'hFF);
            check("bp_cnt0", grant_cnt0, 3);
            check("bp_cnt1", grant_cnt1, 2);
        end
        rsp_ready = 1'b1;
        cycle();
        idle();
        cycle();

        // Illegal opcode and shift boundaries.
        set0(1'b1, 8'h12, 8'h34, 4'b1111);
        cycle();
        check("ill_result", rsp_result, 8'h00);
        check("ill_err", rsp_err, 1'b1);
        set0(1'b1, 8'h81, 8'h01, 4'b1001);
        cycle();
        check("shl_result", rsp_result, 8'h02);
        check("shl_err", rsp_err, 1'b0);
        set0(1'b1, 8'hFF, 8'h09, 4'b1010);
        cycle();
        check("shr9_result", rsp_result, 8'h00);
        idle();
        cycle();

        // Asynchronous reset while FULL.
        set0(1'b1, 8'h05, 8'h03, 4'b0010);
        cycle();
        rsp_ready = 1'b0;
        idle();
        check("pre_rst_valid", rsp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", rsp_valid, 1'b0);
        check("async_rst_cnt0", grant_cnt0, 0);
        check("async_rst_cnt1", grant_cnt1, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set0(1'b1, 8'h01, 8'h02, 4'b0001);
        set1(1'b1, 8'h03, 8'h04, 4'b0001);
        cycle();
        check("post_rst_id", rsp_id, 1'b0);
        idle();
        cycle();

        // Counter saturation.
        apply_reset();
        rsp_ready = 1'b1;
        set1(1'b1, 8'h01, 8'h01, 4'b0001);
        repeat (17) cycle();
        idle();
        check("sat_cnt1", grant_cnt1, 4'hF);
        cycle();

        // Random traffic against the model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            set0(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 10)),
                 op_tab[$urandom_range(0, 7)]);
            set1(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 10)),
                 op_tab[$urandom_range(0, 7)]);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        idle();
        rsp_ready = 1'b1;
        cycle();
        cycle();
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
